// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-to-parallel word assembler with MSB/LSB-first modes and a hold-until-accepted output
module shift_deserializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        msb_first,
  input  logic [4:0]  len,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [15:0] data_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        overrun
);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  state_t state, state_nx;
  logic [15:0] sr, sr_nx, word;
  logic [16:0] mask;
  logic [4:0] cnt, len_q, len_eff;
  logic msb_q, load, take, last;
  always_comb begin
    len_eff = (len == 5'd0 || len > 5'd16) ? 5'd16 : len;
    load = start && (state != HOLD || out_ready);
    take = state == SHIFT && bit_valid && !start;
    last = take && cnt + 5'd1 == len_q;
    sr_nx = msb_q ? {sr[14:0], bit_in} : {bit_in, sr[15:1]};
    mask = (17'h1 << len_q) - 17'h1;
    word = msb_q ? sr_nx & mask[15:0] : sr_nx >> (5'd16 - len_q);
    state_nx = load ? SHIFT : last ? HOLD : (state == HOLD && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      cnt <= '0;
      len_q <= 5'd16;
      msb_q <= 1'b0;
      data_out <= '0;
      overrun <= 1'b0;
    end else if (load) begin
      sr <= '0;
      cnt <= '0;
      len_q <= len_eff;
      msb_q <= msb_first;
      overrun <= 1'b0;
    end else begin
      if (take) begin
        sr <= sr_nx;
        cnt <= cnt + 5'd1;
      end
      if (last) data_out <= word;
      if (state == HOLD && bit_valid) overrun <= 1'b1;
    end
  end
  assign out_valid = state == HOLD;
  assign busy = state == SHIFT;
endmodule

// File: tb/tb_shift_deserializer.sv
// tb_shift_deserializer: directed table and sequence checks for shift_deserializer
module tb_shift_deserializer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, msb_first = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, out_ready = 1'b0;
  logic [4:0] len = 5'd0;
  logic [15:0] data_out;
  logic out_valid, busy, overrun;
  int total = 0, bad = 0;
  typedef struct {
    logic s, m;
    logic [4:0] l;
    logic b, v, r;
    logic ev, eb, eo;
    logic [15:0] ed;
  } vec_t;
  vec_t tbl[14];
  always #5 clk = ~clk;
  shift_deserializer dut (
    .clk(clk), .rst(rst), .start(start), .msb_first(msb_first), .len(len),
    .bit_in(bit_in), .bit_valid(bit_valid), .data_out(data_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .overrun(overrun)
  );
  function automatic logic [18:0] obs();
    return {out_valid, busy, overrun, data_out};
  endfunction
  function automatic logic [18:0] ex(input logic v, b, o, input logic [15:0] d);
    return {v, b, o, d};
  endfunction
  task automatic step(input logic s, m, input logic [4:0] l, input logic b, v, r);
    @(negedge clk);
    start = s; msb_first = m; len = l; bit_in = b; bit_valid = v; out_ready = r;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got valid/busy/ovr/data=%h expected %h", name, act, exp);
    end
  endtask
  initial begin
    logic [15:0] pat;
    logic seen;
    tbl[0]  = '{1, 0, 8, 0, 0, 0, 0, 1, 0, 16'h0000};
    tbl[1]  = '{0, 1, 3, 0, 1, 0, 0, 1, 0, 16'h0000};
    tbl[2]  = '{0, 1, 3, 1, 0, 0, 0, 1, 0, 16'h0000};
    tbl[3]  = '{0, 1, 3, 0, 1, 0, 0, 1, 0, 16'h0000};
    tbl[4]  = '{0, 1, 3, 1, 1, 0, 0, 1, 0, 16'h0000};
    tbl[5]  = '{0, 1, 3, 0, 0, 0, 0, 1, 0, 16'h0000};
    tbl[6]  = '{0, 1, 3, 1, 1, 0, 0, 1, 0, 16'h0000};
    tbl[7]  = '{0, 1, 3, 1, 1, 0, 0, 1, 0, 16'h0000};
    tbl[8]  = '{0, 1, 3, 1, 1, 0, 0, 1, 0, 16'h0000};
    tbl[9]  = '{0, 1, 3, 1, 0, 0, 0, 1, 0, 16'h0000};
    tbl[10] = '{0, 1, 3, 0, 1, 0, 0, 1, 0, 16'h0000};
    tbl[11] = '{0, 1, 3, 0, 1, 0, 1, 0, 0, 16'h003C};
    tbl[12] = '{0, 1, 3, 0, 0, 1, 0, 0, 0, 16'h003C};
    tbl[13] = '{0, 1, 3, 1, 1, 0, 0, 0, 0, 16'h003C};
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 16, 1, 1, 1);
    check("reset", obs(), ex(0, 0, 0, 16'h0000));
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].s, tbl[i].m, tbl[i].l, tbl[i].b, tbl[i].v, tbl[i].r);
      check($sformatf("vec%0d", i), obs(), ex(tbl[i].ev, tbl[i].eb, tbl[i].eo, tbl[i].ed));
    end
    pat = 16'hA5C3;
    step(1, 1, 16, 0, 0, 0);
    for (int i = 15; i >= 0; i--) begin
      step(0, 0, 0, pat[i], 1, 0);
      if (i == 1) check("a5c3_pre", obs(), ex(0, 1, 0, 16'h003C));
    end
    check("a5c3_done", obs(), ex(1, 0, 0, 16'hA5C3));
    step(1, 0, 4, 0, 0, 0);
    check("hold_start_ignored", obs(), ex(1, 0, 0, 16'hA5C3));
    step(0, 0, 0, 0, 0, 1);
    check("a5c3_ack", obs(), ex(0, 0, 0, 16'hA5C3));
    step(1, 1, 8, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 0);
    check("ff_done", obs(), ex(1, 0, 0, 16'h00FF));
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1, 0);
      check($sformatf("ff_hold%0d", i), obs(), ex(1, 0, 1, 16'h00FF));
    end
    step(0, 0, 0, 0, 0, 1);
    check("ff_ack", obs(), ex(0, 0, 1, 16'h00FF));
    step(1, 0, 4, 0, 0, 0);
    check("ovr_clear", obs(), ex(0, 1, 0, 16'h00FF));
    step(1, 1, 16, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 0);
    step(1, 1, 4, 0, 0, 0);
    check("abort_restart", obs(), ex(0, 1, 0, 16'h00FF));
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check("len4_pre", obs(), ex(0, 1, 0, 16'h00FF));
    step(0, 0, 0, 1, 1, 0);
    check("len4_done", obs(), ex(1, 0, 0, 16'h0009));
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, 1, 0);
      if (i == 14) check("len0_pre", obs(), ex(0, 1, 0, 16'h0009));
    end
    check("len0_done", obs(), ex(1, 0, 0, 16'hFFFF));
    step(1, 0, 20, 0, 0, 1);
    check("ack_with_start", obs(), ex(0, 1, 0, 16'hFFFF));
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, i == 0, 1, 0);
      if (i == 14) check("len20_pre", obs(), ex(0, 1, 0, 16'hFFFF));
    end
    check("len20_done", obs(), ex(1, 0, 0, 16'h0001));
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 16, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 1, 0);
    rst = 1'b1;
    step(0, 0, 0, 1, 1, 0);
    check("mid_reset", obs(), ex(0, 0, 0, 16'h0000));
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1, 1, 1);
      seen |= out_valid | busy;
    end
    check("no_start_no_word", {18'h0, seen}, 19'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 The module SHALL have one clock and synchronous active-high reset, listed first in the port list.
REQ-002 Port `clk`: input, 1 bit, rising-edge clock for all state.
REQ-003 Port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 Port `start`: input, 1 bit, begins a new frame; captures `msb_first` and `len`.
REQ-005 Port `msb_first`: input, 1 bit, 1 = first received bit is word MSB (left-shift assembly), 0 = LSB first (right-shift assembly).
REQ-006 Port `len`: input, 5 bits, frame length in bits; 1..16 valid, 0 or >16 treated as 16.
REQ-007 Port `bit_in`: input, 1 bit, serial data.
REQ-008 Port `bit_valid`: input, 1 bit, `bit_in` is sampled this cycle.
REQ-009 Port `data_out`: output, 16 bits, registered assembled word, right-aligned, unused upper bits 0.
REQ-010 Port `out_valid`: output, 1 bit, `data_out` holds a completed word.
REQ-011 Port `out_ready`: input, 1 bit, consumer accepts the word when `out_valid` && `out_ready`.
REQ-012 Port `busy`: output, 1 bit, high in SHIFT state.
REQ-013 Port `overrun`: output, 1 bit, sticky flag for a bit dropped while in HOLD.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and HOLD.
REQ-015 In IDLE, `start`=1 SHALL go to SHIFT, latch mode/effective length, clear the 16-bit shift register and 5-bit count, and clear `overrun`.
REQ-016 In IDLE, `bit_valid` SHALL be ignored.
REQ-017 In SHIFT with `bit_valid`=1 and `msb_first`=1, the shift register SHALL load {sr[14:0], bit_in}.
REQ-018 In SHIFT with `bit_valid`=1 and `msb_first`=0, the shift register SHALL load {bit_in, sr[15:1]}.
REQ-019 In SHIFT, count SHALL increment by 1 per accepted bit; `bit_valid`=0 cycles SHALL hold all state, with no timeout.
REQ-020 On the edge accepting bit number len, the block SHALL go to HOLD and load `data_out`.
REQ-021 The loaded `data_out` SHALL be the MSB-first result unchanged (masked to len bits), or the LSB-first result right-shifted by (16 - len).
REQ-022 `out_valid` SHALL rise in the cycle after the final bit edge (latency 1).
REQ-023 `start`=1 in SHIFT SHALL abort the frame and restart it (count 0, register cleared, new mode/len latched), emitting no word.
REQ-024 In HOLD, `out_valid` and `data_out` SHALL stay stable until handshake; on handshake `out_valid` clears next cycle.
REQ-025 On handshake without `start`, the block SHALL go to IDLE.
REQ-026 On handshake with simultaneous `start`, the block SHALL go directly to SHIFT for a new frame.
REQ-027 `start` in HOLD without handshake SHALL be ignored.
REQ-028 `bit_valid`=1 in HOLD SHALL drop the bit and set `overrun`, which remains set until the next accepted `start` or reset.
REQ-029 `data_out` SHALL retain the last word after handshake until the next completion.

Reset
REQ-030 `rst`=1 at a clock edge SHALL force IDLE with `data_out`=0x0000, `out_valid`=0, `busy`=0, `overrun`=0, count=0 and shift register=0.
REQ-031 Reset SHALL take priority over all inputs, including mid-SHIFT and mid-HOLD.

Verification
REQ-032 Scenario: start, msb_first=1, len=16, bits 1010_0101_1100_0011 with gap-free bit_valid -> out_valid high one cycle after 16th bit, data_out=0xA5C3.
REQ-033 Scenario: start, msb_first=0, len=8, bits 0,0,1,1,1,1,0,0 with random bit_valid gaps -> data_out=0x003C, busy low after completion.
REQ-034 Scenario: complete 0x00FF (len=8), hold out_ready=0 for 5 cycles while pulsing bit_valid -> data_out stays 0x00FF, overrun=1; out_ready=1 -> out_valid=0 next cycle; next start clears overrun.
REQ-035 Scenario: rst asserted after 7 of 16 bits -> next cycle all outputs 0 and state IDLE; bits fed without start produce no out_valid.
REQ-036 Scenario: start after 5 bits of a len=16 frame, then 4 bits 1,0,0,1 with len=4, msb_first=1 -> single word data_out=0x0009.
REQ-037 Scenario: len=0 and len=20 -> each frame completes after exactly 16 bits.
